baud_gen_frac: RTL

Parametrised fractional baud-rate generator for the UART. From the system clock it produces a one-cycle oversample strobe (`os_tick`, OVERSAMPLE × baud), a bit strobe (`bit_tick`, 1 × baud) and a mid-bit strobe (`mid_tick`) for the RX sampler. Unlike the fixed single-tick generator, it has:
- a runtime-loadable integer + fractional divisor with an enable,
- configuration error detection,
- a zero-drift average period.

It sits between the register block (divisor source) and the UART TX/RX engines.

---
 rtl/baud_gen_frac.sv | 116 +++++++++++
 1 files changed

// File: rtl/baud_gen_frac.sv
// Fractional UART baud generator: os_tick (OVERSAMPLE x baud), bit_tick and mid_tick strobes.
// Latency: first os_tick one full period (act_int + carry) after en is sampled high or after a load.
// Backpressure: none; the strobes are free-running single-cycle pulses and consumers must take them.
module baud_gen_frac #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int DEF_DIV_INT  = 27,
    parameter int DEF_DIV_FRAC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              mid_tick,
    output logic              cfg_err
);

    localparam int CNT_W = DIV_W + 1;
    localparam int IDX_W = $clog2(OVERSAMPLE);

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_MID  = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_DIV_INT);
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_DIV_FRAC);

    // Carry out of the fractional accumulator addition a + b.
    function automatic logic frac_carry(input logic [FRAC_W-1:0] a, input logic [FRAC_W-1:0] b);
        logic [FRAC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[FRAC_W];
    endfunction

    // Down-counter start value for a period of (i + c) cycles; one bit wider so
    // the maximum divisor plus a carry cannot overflow.
    function automatic logic [CNT_W-1:0] reload_val(input logic [DIV_W-1:0] i, input logic c);
        return {1'b0, i} - CNT_W'(1) + CNT_W'(c);
    endfunction

    localparam logic [CNT_W-1:0] RST_CNT = reload_val(DEF_INT, frac_carry('0, DEF_FRAC));

    logic [DIV_W-1:0]  act_int,  act_int_nxt;
    logic [FRAC_W-1:0] act_frac, act_frac_nxt;
    logic [CNT_W-1:0]  cnt,      cnt_nxt;
    logic [FRAC_W-1:0] acc,      acc_nxt;
    logic [IDX_W-1:0]  os_idx,   idx_nxt;
    logic [FRAC_W-1:0] acc_step;
    logic              os_nxt, bit_nxt, mid_nxt;

    assign cfg_err = (act_int < DIV_W'(2));

    // Next-state: load beats enable; idle whenever disabled or misconfigured;
    // otherwise count down and, at zero, emit a tick and pick the next period length.
    always_comb begin
        act_int_nxt  = act_int;
        act_frac_nxt = act_frac;
        cnt_nxt      = cnt;
        acc_nxt      = acc;
        idx_nxt      = os_idx;
        os_nxt       = 1'b0;
        bit_nxt      = 1'b0;
        mid_nxt      = 1'b0;
        acc_step     = acc + act_frac;

        if (load) begin
            act_int_nxt  = div_int;
            act_frac_nxt = div_frac;
            cnt_nxt      = reload_val(div_int, frac_carry('0, div_frac));
            acc_nxt      = '0;
            idx_nxt      = '0;
        end else if (!en || cfg_err) begin
            cnt_nxt = reload_val(act_int, frac_carry('0, act_frac));
            acc_nxt = '0;
            idx_nxt = '0;
        end else if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
        end else begin
            os_nxt  = 1'b1;
            bit_nxt = (os_idx == IDX_LAST);
            mid_nxt = (os_idx == IDX_MID);
            acc_nxt = acc_step;
            // The period about to start is stretched by the carry of the
            // accumulator addition that will close it.
            cnt_nxt = reload_val(act_int, frac_carry(acc_step, act_frac));
            idx_nxt = (os_idx == IDX_LAST) ? '0 : os_idx + IDX_W'(1);
        end
    end

    // State and registered strobes; reset returns to the default divisor at idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_int  <= DEF_INT;
            act_frac <= DEF_FRAC;
            cnt      <= RST_CNT;
            acc      <= '0;
            os_idx   <= '0;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
        end else begin
            act_int  <= act_int_nxt;
            act_frac <= act_frac_nxt;
            cnt      <= cnt_nxt;
            acc      <= acc_nxt;
            os_idx   <= idx_nxt;
            os_tick  <= os_nxt;
            bit_tick <= bit_nxt;
            mid_tick <= mid_nxt;
        end
    end

endmodule
